// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the two-port RAM access arbiter.
// Includes the FSM state encoding and the fixed geometry of the 8-row RAM.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } state_e;

    localparam int RAM_ADDR_W = 3;
    localparam int RAM_ROWS   = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
// The grant is combinational. A registered last-winner pointer breaks ties.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [1:0] Req,
    input  logic       Update,
    output logic [1:0] Grant
);

    logic last_q;
    logic last_d;

    // On a tie, the port that did not win last time is granted.
    always_comb begin
        Grant = 2'b00;
        case (Req)
            2'b01:   Grant = 2'b01;
            2'b10:   Grant = 2'b10;
            2'b11:   Grant = last_q ? 2'b01 : 2'b10;
            default: Grant = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (Update && (Grant != 2'b00)) begin
            last_d = Grant[1];
        end
    end

    // Reset to "port 1 won last" so that port 0 wins the first tie.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one 8-row RAM between two req/ack clients.
// Each access is a three-cycle sequence: IDLE (grant), ACCESS (pins driven), ACK (pulse).
module ram_access_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Wr0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [WIDTH-1:0]  WData0,
    output logic              Ack0,
    output logic [WIDTH-1:0]  RData0,
    input  logic              Req1,
    input  logic              Wr1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [WIDTH-1:0]  WData1,
    output logic              Ack1,
    output logic [WIDTH-1:0]  RData1,
    output logic              RamCS,
    output logic              RamRWS,
    output logic [ADDR_W-1:0] RamAddress,
    output logic [WIDTH-1:0]  RamDataIn,
    input  logic [WIDTH-1:0]  RamDataOut
);

    state_e            state_q;
    logic              gnt_q;
    logic              cs_q;
    logic              rws_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  din_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [WIDTH-1:0]  rdata0_q;
    logic [WIDTH-1:0]  rdata1_q;

    logic [1:0]        arb_req;
    logic [1:0]        arb_grant;
    logic              arb_update;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_wdata;

    // In ACK the arbiter sees only the granted port, so its pointer records that port.
    assign arb_req    = (state_q == ACK) ? {gnt_q, ~gnt_q} : {Req1, Req0};
    assign arb_update = (state_q == ACK);

    rr_arbiter2 u_arb (
        .CLK    (CLK),
        .Reset  (Reset),
        .Req    (arb_req),
        .Update (arb_update),
        .Grant  (arb_grant)
    );

    assign sel_wr    = arb_grant[1] ? Wr1    : Wr0;
    assign sel_addr  = arb_grant[1] ? Addr1  : Addr0;
    assign sel_wdata = arb_grant[1] ? WData1 : WData0;

    // The RAM pin registers double as the registered command of the access in flight.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            cs_q     <= 1'b0;
            rws_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_grant != 2'b00) begin
                        gnt_q   <= arb_grant[1];
                        cs_q    <= 1'b1;
                        rws_q   <= sel_wr;
                        addr_q  <= sel_addr;
                        din_q   <= sel_wr ? sel_wdata : '0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!rws_q) begin
                        if (gnt_q) begin
                            rdata1_q <= RamDataOut;
                        end else begin
                            rdata0_q <= RamDataOut;
                        end
                    end
                    cs_q    <= 1'b0;
                    rws_q   <= 1'b0;
                    addr_q  <= '0;
                    din_q   <= '0;
                    ack0_q  <= ~gnt_q;
                    ack1_q  <= gnt_q;
                    state_q <= ACK;
                end
                ACK: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign RamCS      = cs_q;
    assign RamRWS     = rws_q;
    assign RamAddress = addr_q;
    assign RamDataIn  = din_q;
    assign Ack0       = ack0_q;
    assign Ack1       = ack1_q;
    assign RData0     = rdata0_q;
    assign RData1     = rdata1_q;

endmodule
